// File: rtl/multicycle_control.sv
// Multi-cycle main control FSM for the RV32I core: sequences fetch/decode/execute/memory/
// writeback against a req/ready memory port and drives datapath selects and enables.
module multicycle_control #(
   parameter int ALU_OP_W    = 2,
   parameter int SUPPORT_JAL = 1,
   parameter int MEM_TIMEOUT = 16
) (
   input  logic                i_clk,
   input  logic                i_rst_n,
   input  logic [6:0]          i_opcode,
   input  logic                i_mem_ready,
   output logic                o_mem_req,
   output logic                o_mem_read,
   output logic                o_mem_write,
   output logic                o_iord,
   output logic                o_ir_write,
   output logic                o_pc_write,
   output logic                o_branch,
   output logic                o_pc_src,
   output logic [1:0]          o_alu_src_a,
   output logic [1:0]          o_alu_src_b,
   output logic [ALU_OP_W-1:0] o_alu_op,
   output logic                o_reg_write,
   output logic [1:0]          o_mem_to_reg,
   output logic                o_retire,
   output logic                o_illegal,
   output logic                o_bus_err
);

   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_I     = 7'b0010011;
   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_BEQ   = 7'b1100011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;

   localparam logic [ALU_OP_W-1:0] ALU_ADD    = ALU_OP_W'(0);
   localparam logic [ALU_OP_W-1:0] ALU_SUB    = ALU_OP_W'(1);
   localparam logic [ALU_OP_W-1:0] ALU_FUNC_R = ALU_OP_W'(2);
   localparam logic [ALU_OP_W-1:0] ALU_FUNC_I = ALU_OP_W'(3);

   localparam logic [1:0] SRC_A_PC     = 2'b00;
   localparam logic [1:0] SRC_A_RS1    = 2'b01;
   localparam logic [1:0] SRC_A_OLD_PC = 2'b10;
   localparam logic [1:0] SRC_B_RS2    = 2'b00;
   localparam logic [1:0] SRC_B_FOUR   = 2'b01;
   localparam logic [1:0] SRC_B_IMM    = 2'b10;
   localparam logic [1:0] WB_ALUOUT    = 2'b00;
   localparam logic [1:0] WB_MDR       = 2'b01;
   localparam logic [1:0] WB_LINK      = 2'b10;

   typedef enum logic [3:0] {
      S_RESET   = 4'd0,
      S_FETCH   = 4'd1,
      S_DECODE  = 4'd2,
      S_EXEC_R  = 4'd3,
      S_EXEC_I  = 4'd4,
      S_ALU_WB  = 4'd5,
      S_ADDR    = 4'd6,
      S_MEM_RD  = 4'd7,
      S_LOAD_WB = 4'd8,
      S_MEM_WR  = 4'd9,
      S_BRANCH  = 4'd10,
      S_JAL     = 4'd11,
      S_TRAP    = 4'd12
   } state_t;

   state_t state_reg;
   state_t state_next;
   logic   illegal_reg;
   logic   bus_err_reg;
   logic   wait_state;
   logic   timeout;
   logic   jal_ok;

   assign jal_ok     = (SUPPORT_JAL != 0);
   assign wait_state = (state_reg == S_FETCH) || (state_reg == S_MEM_RD) ||
                       (state_reg == S_MEM_WR);

   // Watchdog: counts not-ready cycles of the current access; cleared on every state change.
   generate
      if (MEM_TIMEOUT > 0) begin : g_wdog
         localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
         logic [CNT_W-1:0] cnt_reg;
         logic [CNT_W-1:0] cnt_next;

         always_comb begin
            cnt_next = cnt_reg;
            if (state_next != state_reg) begin
               cnt_next = '0;
            end else if (wait_state && !i_mem_ready) begin
               cnt_next = cnt_reg + CNT_W'(1);
            end
         end

         always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
               cnt_reg <= '0;
            end else begin
               cnt_reg <= cnt_next;
            end
         end

         assign timeout = wait_state && !i_mem_ready && (cnt_reg == CNT_W'(MEM_TIMEOUT));
      end else begin : g_no_wdog
         assign timeout = 1'b0;
      end
   endgenerate

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_reg <= S_RESET;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_RESET:   state_next = S_FETCH;
         S_FETCH: begin
            if (i_mem_ready) begin
               state_next = S_DECODE;
            end else if (timeout) begin
               state_next = S_TRAP;
            end
         end
         S_DECODE: begin
            case (i_opcode)
               OP_R:     state_next = S_EXEC_R;
               OP_I:     state_next = S_EXEC_I;
               OP_LOAD:  state_next = S_ADDR;
               OP_STORE: state_next = S_ADDR;
               OP_BEQ:   state_next = S_BRANCH;
               OP_JAL:   state_next = jal_ok ? S_JAL : S_TRAP;
               default:  state_next = S_TRAP;
            endcase
         end
         S_EXEC_R:  state_next = S_ALU_WB;
         S_EXEC_I:  state_next = S_ALU_WB;
         S_ALU_WB:  state_next = S_FETCH;
         S_ADDR:    state_next = (i_opcode == OP_STORE) ? S_MEM_WR : S_MEM_RD;
         S_MEM_RD: begin
            if (i_mem_ready) begin
               state_next = S_LOAD_WB;
            end else if (timeout) begin
               state_next = S_TRAP;
            end
         end
         S_LOAD_WB: state_next = S_FETCH;
         S_MEM_WR: begin
            if (i_mem_ready) begin
               state_next = S_FETCH;
            end else if (timeout) begin
               state_next = S_TRAP;
            end
         end
         S_BRANCH:  state_next = S_FETCH;
         S_JAL:     state_next = S_FETCH;
         S_TRAP:    state_next = S_TRAP;
         default:   state_next = S_RESET;
      endcase
   end

   // Sticky trap causes; only a reset clears them.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         illegal_reg <= 1'b0;
         bus_err_reg <= 1'b0;
      end else begin
         if ((state_reg == S_DECODE) && (state_next == S_TRAP)) begin
            illegal_reg <= 1'b1;
         end
         if (timeout) begin
            bus_err_reg <= 1'b1;
         end
      end
   end

   always_comb begin
      o_mem_req    = 1'b0;
      o_mem_read   = 1'b0;
      o_mem_write  = 1'b0;
      o_iord       = 1'b0;
      o_ir_write   = 1'b0;
      o_pc_write   = 1'b0;
      o_branch     = 1'b0;
      o_pc_src     = 1'b0;
      o_alu_src_a  = SRC_A_PC;
      o_alu_src_b  = SRC_B_RS2;
      o_alu_op     = ALU_ADD;
      o_reg_write  = 1'b0;
      o_mem_to_reg = WB_ALUOUT;
      o_retire     = 1'b0;
      o_illegal    = illegal_reg;
      o_bus_err    = bus_err_reg;
      case (state_reg)
         S_FETCH: begin
            o_mem_req   = 1'b1;
            o_mem_read  = 1'b1;
            o_alu_src_a = SRC_A_PC;
            o_alu_src_b = SRC_B_FOUR;
            o_alu_op    = ALU_ADD;
            o_ir_write  = i_mem_ready;
            o_pc_write  = i_mem_ready;
         end
         S_DECODE: begin
            // Branch target is computed speculatively into ALUOut.
            o_alu_src_a = SRC_A_OLD_PC;
            o_alu_src_b = SRC_B_IMM;
            o_alu_op    = ALU_ADD;
         end
         S_EXEC_R: begin
            o_alu_src_a = SRC_A_RS1;
            o_alu_src_b = SRC_B_RS2;
            o_alu_op    = ALU_FUNC_R;
         end
         S_EXEC_I: begin
            o_alu_src_a = SRC_A_RS1;
            o_alu_src_b = SRC_B_IMM;
            o_alu_op    = ALU_FUNC_I;
         end
         S_ALU_WB: begin
            o_reg_write  = 1'b1;
            o_mem_to_reg = WB_ALUOUT;
            o_retire     = 1'b1;
         end
         S_ADDR: begin
            o_alu_src_a = SRC_A_RS1;
            o_alu_src_b = SRC_B_IMM;
            o_alu_op    = ALU_ADD;
         end
         S_MEM_RD: begin
            o_mem_req  = 1'b1;
            o_mem_read = 1'b1;
            o_iord     = 1'b1;
         end
         S_LOAD_WB: begin
            o_reg_write  = 1'b1;
            o_mem_to_reg = WB_MDR;
            o_retire     = 1'b1;
         end
         S_MEM_WR: begin
            o_mem_req   = 1'b1;
            o_mem_write = 1'b1;
            o_iord      = 1'b1;
            o_retire    = i_mem_ready;
         end
         S_BRANCH: begin
            o_alu_src_a = SRC_A_RS1;
            o_alu_src_b = SRC_B_RS2;
            o_alu_op    = ALU_SUB;
            o_branch    = 1'b1;
            o_pc_src    = 1'b1;
            o_retire    = 1'b1;
         end
         S_JAL: begin
            o_reg_write  = 1'b1;
            o_mem_to_reg = WB_LINK;
            o_pc_write   = 1'b1;
            o_pc_src     = 1'b1;
            o_retire     = 1'b1;
         end
         default: begin
         end
      endcase
   end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: two instances (JAL + 4-cycle watchdog, and
// no-JAL + watchdog disabled) checked cycle by cycle against hand-built control words.
module tb_multicycle_control;

   logic       clk;
   logic       rst_a;
   logic       rst_b;
   logic [6:0] opcode;
   logic       ready;

   logic       a_mem_req, a_mem_read, a_mem_write, a_iord, a_ir_write, a_pc_write;
   logic       a_branch, a_pc_src, a_reg_write, a_retire, a_illegal, a_bus_err;
   logic [1:0] a_src_a, a_src_b, a_alu_op, a_mem_to_reg;
   logic       b_mem_req, b_mem_read, b_mem_write, b_iord, b_ir_write, b_pc_write;
   logic       b_branch, b_pc_src, b_reg_write, b_retire, b_illegal, b_bus_err;
   logic [1:0] b_src_a, b_src_b, b_alu_op, b_mem_to_reg;

   int n_cmp  = 0;
   int n_fail = 0;

   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_I     = 7'b0010011;
   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_BEQ   = 7'b1100011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_BAD   = 7'b1111111;

   // Word layout: req rd wr iord | irw pcw br pcs | src_a src_b | alu_op rw m2r | ret ill berr
   localparam logic [19:0] E_ZERO = 20'h0;
   localparam logic [19:0] E_FW   = {4'b1100, 4'b0000, 2'b00, 2'b01, 2'b00, 1'b0, 2'b00, 3'b000};
   localparam logic [19:0] E_FR   = {4'b1100, 4'b1100, 2'b00, 2'b01, 2'b00, 1'b0, 2'b00, 3'b000};
   localparam logic [19:0] E_DEC  = {4'b0000, 4'b0000, 2'b10, 2'b10, 2'b00, 1'b0, 2'b00, 3'b000};
   localparam logic [19:0] E_EXR  = {4'b0000, 4'b0000, 2'b01, 2'b00, 2'b10, 1'b0, 2'b00, 3'b000};
   localparam logic [19:0] E_EXI  = {4'b0000, 4'b0000, 2'b01, 2'b10, 2'b11, 1'b0, 2'b00, 3'b000};
   localparam logic [19:0] E_AWB  = {4'b0000, 4'b0000, 2'b00, 2'b00, 2'b00, 1'b1, 2'b00, 3'b100};
   localparam logic [19:0] E_ADDR = {4'b0000, 4'b0000, 2'b01, 2'b10, 2'b00, 1'b0, 2'b00, 3'b000};
   localparam logic [19:0] E_MRD  = {4'b1101, 4'b0000, 2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 3'b000};
   localparam logic [19:0] E_LWB  = {4'b0000, 4'b0000, 2'b00, 2'b00, 2'b00, 1'b1, 2'b01, 3'b100};
   localparam logic [19:0] E_MWW  = {4'b1011, 4'b0000, 2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 3'b000};
   localparam logic [19:0] E_MWR  = {4'b1011, 4'b0000, 2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 3'b100};
   localparam logic [19:0] E_BR   = {4'b0000, 4'b0011, 2'b01, 2'b00, 2'b01, 1'b0, 2'b00, 3'b100};
   localparam logic [19:0] E_JAL  = {4'b0000, 4'b0101, 2'b00, 2'b00, 2'b00, 1'b1, 2'b10, 3'b100};
   localparam logic [19:0] E_TILL = {4'b0000, 4'b0000, 2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 3'b010};
   localparam logic [19:0] E_TBUS = {4'b0000, 4'b0000, 2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 3'b001};

   logic [19:0] obs_a;
   logic [19:0] obs_b;
   assign obs_a = {a_mem_req, a_mem_read, a_mem_write, a_iord, a_ir_write, a_pc_write,
                   a_branch, a_pc_src, a_src_a, a_src_b, a_alu_op, a_reg_write,
                   a_mem_to_reg, a_retire, a_illegal, a_bus_err};
   assign obs_b = {b_mem_req, b_mem_read, b_mem_write, b_iord, b_ir_write, b_pc_write,
                   b_branch, b_pc_src, b_src_a, b_src_b, b_alu_op, b_reg_write,
                   b_mem_to_reg, b_retire, b_illegal, b_bus_err};

   multicycle_control #(.ALU_OP_W(2), .SUPPORT_JAL(1), .MEM_TIMEOUT(4)) dut_a (
      .i_clk(clk), .i_rst_n(rst_a), .i_opcode(opcode), .i_mem_ready(ready),
      .o_mem_req(a_mem_req), .o_mem_read(a_mem_read), .o_mem_write(a_mem_write),
      .o_iord(a_iord), .o_ir_write(a_ir_write), .o_pc_write(a_pc_write),
      .o_branch(a_branch), .o_pc_src(a_pc_src), .o_alu_src_a(a_src_a),
      .o_alu_src_b(a_src_b), .o_alu_op(a_alu_op), .o_reg_write(a_reg_write),
      .o_mem_to_reg(a_mem_to_reg), .o_retire(a_retire), .o_illegal(a_illegal),
      .o_bus_err(a_bus_err)
   );

   multicycle_control #(.ALU_OP_W(2), .SUPPORT_JAL(0), .MEM_TIMEOUT(0)) dut_b (
      .i_clk(clk), .i_rst_n(rst_b), .i_opcode(opcode), .i_mem_ready(ready),
      .o_mem_req(b_mem_req), .o_mem_read(b_mem_read), .o_mem_write(b_mem_write),
      .o_iord(b_iord), .o_ir_write(b_ir_write), .o_pc_write(b_pc_write),
      .o_branch(b_branch), .o_pc_src(b_pc_src), .o_alu_src_a(b_src_a),
      .o_alu_src_b(b_src_b), .o_alu_op(b_alu_op), .o_reg_write(b_reg_write),
      .o_mem_to_reg(b_mem_to_reg), .o_retire(b_retire), .o_illegal(b_illegal),
      .o_bus_err(b_bus_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Inputs change on the falling edge; outputs are sampled 1 ns later.
   task automatic next_cycle(input logic rdy, input logic [6:0] op);
      @(negedge clk);
      ready  = rdy;
      opcode = op;
      #1;
   endtask

   task automatic check(input string tag, input logic [19:0] obs, input logic [19:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %05h expected %05h", tag, obs, exp);
      end
   endtask

   task automatic note(input string what);
      $display("[%0t] txn: %s", $time, what);
   endtask

   initial begin
      rst_a  = 1'b0;
      rst_b  = 1'b0;
      ready  = 1'b0;
      opcode = 7'h00;
      next_cycle(1'b0, 7'h00);
      next_cycle(1'b0, 7'h00);
      check("a_in_reset", obs_a, E_ZERO);
      check("b_in_reset", obs_b, E_ZERO);

      @(negedge clk);
      rst_a = 1'b1;
      #1;
      check("a_reset_state", obs_a, E_ZERO);

      note("R-type, zero wait");
      next_cycle(1'b1, OP_R); check("r_fetch", obs_a, E_FR);
      next_cycle(1'b1, OP_R); check("r_decode", obs_a, E_DEC);
      next_cycle(1'b1, OP_R); check("r_exec", obs_a, E_EXR);
      next_cycle(1'b1, OP_R); check("r_wb", obs_a, E_AWB);

      note("I-type, zero wait");
      next_cycle(1'b1, OP_I); check("i_fetch", obs_a, E_FR);
      next_cycle(1'b1, OP_I); check("i_decode", obs_a, E_DEC);
      next_cycle(1'b1, OP_I); check("i_exec", obs_a, E_EXI);
      next_cycle(1'b1, OP_I); check("i_wb", obs_a, E_AWB);

      note("load, two wait cycles in MEM_RD");
      next_cycle(1'b1, OP_LOAD); check("ld_fetch", obs_a, E_FR);
      next_cycle(1'b1, OP_LOAD); check("ld_decode", obs_a, E_DEC);
      next_cycle(1'b1, OP_LOAD); check("ld_addr", obs_a, E_ADDR);
      next_cycle(1'b0, OP_LOAD); check("ld_mem_w1", obs_a, E_MRD);
      next_cycle(1'b0, OP_LOAD); check("ld_mem_w2", obs_a, E_MRD);
      next_cycle(1'b1, OP_LOAD); check("ld_mem_rdy", obs_a, E_MRD);
      next_cycle(1'b1, OP_LOAD); check("ld_wb", obs_a, E_LWB);

      note("store, one wait cycle in MEM_WR");
      next_cycle(1'b1, OP_STORE); check("st_fetch", obs_a, E_FR);
      next_cycle(1'b1, OP_STORE); check("st_decode", obs_a, E_DEC);
      next_cycle(1'b1, OP_STORE); check("st_addr", obs_a, E_ADDR);
      next_cycle(1'b0, OP_STORE); check("st_mem_wait", obs_a, E_MWW);
      next_cycle(1'b1, OP_STORE); check("st_mem_rdy", obs_a, E_MWR);

      note("beq");
      next_cycle(1'b1, OP_BEQ); check("beq_fetch", obs_a, E_FR);
      next_cycle(1'b1, OP_BEQ); check("beq_decode", obs_a, E_DEC);
      next_cycle(1'b1, OP_BEQ); check("beq_exec", obs_a, E_BR);

      note("jal");
      next_cycle(1'b1, OP_JAL); check("jal_fetch", obs_a, E_FR);
      next_cycle(1'b1, OP_JAL); check("jal_decode", obs_a, E_DEC);
      next_cycle(1'b1, OP_JAL); check("jal_exec", obs_a, E_JAL);

      note("R-type, ready arrives when watchdog count reaches limit");
      for (int i = 0; i < 4; i++) begin
         next_cycle(1'b0, OP_R); check("edge_fetch_wait", obs_a, E_FW);
      end
      next_cycle(1'b1, OP_R); check("edge_fetch_rdy", obs_a, E_FR);
      next_cycle(1'b1, OP_R); check("edge_decode", obs_a, E_DEC);
      next_cycle(1'b1, OP_R); check("edge_exec", obs_a, E_EXR);
      next_cycle(1'b1, OP_R); check("edge_wb", obs_a, E_AWB);

      note("store interrupted by reset during wait");
      next_cycle(1'b1, OP_STORE); check("rst_st_fetch", obs_a, E_FR);
      next_cycle(1'b1, OP_STORE); check("rst_st_decode", obs_a, E_DEC);
      next_cycle(1'b1, OP_STORE); check("rst_st_addr", obs_a, E_ADDR);
      next_cycle(1'b0, OP_STORE); check("rst_st_wait", obs_a, E_MWW);
      #2;
      rst_a = 1'b0;
      #1;
      check("rst_async_drop", obs_a, E_ZERO);
      next_cycle(1'b0, OP_STORE); check("rst_held", obs_a, E_ZERO);
      @(negedge clk);
      rst_a = 1'b1;
      #1;
      check("rst_release", obs_a, E_ZERO);

      note("fetch watchdog expiry");
      for (int i = 0; i < 5; i++) begin
         next_cycle(1'b0, OP_R); check("wd_fetch_wait", obs_a, E_FW);
      end
      for (int i = 0; i < 3; i++) begin
         next_cycle(1'b0, OP_R); check("wd_trap", obs_a, E_TBUS);
      end

      note("illegal opcode 1111111");
      @(negedge clk);
      rst_a = 1'b0;
      #1;
      check("ill_reset", obs_a, E_ZERO);
      @(negedge clk);
      rst_a = 1'b1;
      next_cycle(1'b1, OP_BAD); check("ill_fetch", obs_a, E_FR);
      next_cycle(1'b1, OP_BAD); check("ill_decode", obs_a, E_DEC);
      for (int i = 0; i < 10; i++) begin
         next_cycle(1'b1, OP_R); check("ill_trap", obs_a, E_TILL);
      end

      note("no-JAL instance: watchdog disabled, jal traps");
      @(negedge clk);
      rst_a = 1'b0;
      rst_b = 1'b1;
      #1;
      check("b_reset_state", obs_b, E_ZERO);
      check("a_held_reset", obs_a, E_ZERO);
      for (int i = 0; i < 20; i++) begin
         next_cycle(1'b0, OP_JAL); check("b_fetch_nowd", obs_b, E_FW);
      end
      next_cycle(1'b1, OP_JAL); check("b_fetch_rdy", obs_b, E_FR);
      next_cycle(1'b1, OP_JAL); check("b_decode", obs_b, E_DEC);
      for (int i = 0; i < 10; i++) begin
         next_cycle(1'b1, OP_JAL); check("b_jal_trap", obs_b, E_TILL);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
